// File: rtl/plotfour_pkg.sv
// Shared definitions for the plotfour board renderer: colour codes,
// default board geometry and the renderer state encoding.
package plotfour_pkg;

  // Pixel colours, {R,G,B}
  localparam logic [2:0] COL_GRID    = 3'b111;
  localparam logic [2:0] COL_EMPTY   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_ILLEGAL = 3'b101;

  // Default board geometry inside the 160x120 frame buffer
  localparam int DEF_COLS    = 4;
  localparam int DEF_ROWS    = 5;
  localparam int DEF_SQ_SIZE = 16;
  localparam int DEF_X0      = 48;
  localparam int DEF_Y0      = 20;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} render_state_t;

  // Interior colour of a square from its two occupancy bits; both set
  // should never happen and is shown as magenta so it stands out.
  function automatic logic [2:0] square_colour(input logic b, input logic r);
    case ({b, r})
      2'b00:   return COL_EMPTY;
      2'b10:   return COL_BLUE;
      2'b01:   return COL_RED;
      default: return COL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/square_scan_counter.sv
// Pixel scan counter for the board renderer: px runs fastest, then py,
// then the square index. 'skip' jumps straight to the next square.
module square_scan_counter #(
  parameter int SQ_SIZE = 16,
  parameter int NSQ     = 20,
  parameter int PW      = $clog2(SQ_SIZE),
  parameter int IW      = (NSQ > 1) ? $clog2(NSQ) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic          skip,
  output logic [PW-1:0] px,
  output logic [PW-1:0] py,
  output logic [IW-1:0] idx,
  output logic          px_wrap,
  output logic          py_wrap,
  output logic          last_square,
  output logic          last_pixel
);

  assign px_wrap     = (px == PW'(SQ_SIZE - 1));
  assign py_wrap     = (py == PW'(SQ_SIZE - 1));
  assign last_square = (idx == IW'(NSQ - 1));
  assign last_pixel  = px_wrap && py_wrap && last_square;

  // Advance the scan position; clear has priority, a skip restarts the
  // pixel counters on the following square.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px  <= '0;
      py  <= '0;
      idx <= '0;
    end else if (clr) begin
      px  <= '0;
      py  <= '0;
      idx <= '0;
    end else if (skip) begin
      px  <= '0;
      py  <= '0;
      idx <= idx + 1'b1;
    end else if (en) begin
      if (px_wrap) begin
        px <= '0;
        if (py_wrap) begin
          py  <= '0;
          idx <= idx + 1'b1;
        end else begin
          py <= py + 1'b1;
        end
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Paints the blue/red board occupancy into the VGA frame buffer one pixel
// per clock. Define BOARD_RENDERER_DIRTY_ONLY_EN to repaint only squares
// whose contents changed since they were last drawn.
module board_renderer
  import plotfour_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int SQ_SIZE = DEF_SQ_SIZE,
  parameter int X0      = DEF_X0,
  parameter int Y0      = DEF_Y0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [COLS*ROWS-1:0] blue,
  input  logic [COLS*ROWS-1:0] red,
  input  logic                 draw_req,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  localparam int NSQ = COLS * ROWS;
  localparam int PW  = $clog2(SQ_SIZE);
  localparam int IW  = (NSQ > 1) ? $clog2(NSQ) : 1;

  render_state_t  state, state_next;
  logic [NSQ-1:0] snap_blue, snap_red;
  logic           pending;
  logic           board_changed;
  logic [PW-1:0]  px, py;
  logic [IW-1:0]  idx;
  logic           px_wrap, py_wrap, last_square, last_pixel;
  logic           skip;
  logic           draw_end;
  logic [7:0]     pix_x;
  logic [6:0]     pix_y;
  logic [2:0]     pix_colour;

  assign board_changed = (blue != snap_blue) || (red != snap_red);
  assign draw_end      = skip ? last_square : last_pixel;

  square_scan_counter #(
    .SQ_SIZE (SQ_SIZE),
    .NSQ     (NSQ),
    .PW      (PW),
    .IW      (IW)
  ) u_scan (
    .clock       (clock),
    .reset       (reset),
    .clr         (state == LOAD),
    .en          (state == DRAW),
    .skip        (skip),
    .px          (px),
    .py          (py),
    .idx         (idx),
    .px_wrap     (px_wrap),
    .py_wrap     (py_wrap),
    .last_square (last_square),
    .last_pixel  (last_pixel)
  );

`ifdef BOARD_RENDERER_DIRTY_ONLY_EN
  logic [NSQ-1:0] drawn_blue, drawn_red, force_paint;

  assign skip = (state == DRAW) && !force_paint[idx] &&
                (snap_blue[idx] == drawn_blue[idx]) &&
                (snap_red[idx] == drawn_red[idx]);

  // Remember what each square shows once its last pixel is out; a redraw
  // request forces every square to be painted again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drawn_blue  <= '0;
      drawn_red   <= '0;
      force_paint <= '1;
    end else begin
      if (state == DRAW && !skip && px_wrap && py_wrap) begin
        drawn_blue[idx]  <= snap_blue[idx];
        drawn_red[idx]   <= snap_red[idx];
        force_paint[idx] <= 1'b0;
      end
      if (draw_req) begin
        force_paint <= '1;
      end
    end
  end
`else
  logic unused_wraps;

  assign skip         = 1'b0;
  assign unused_wraps = px_wrap ^ py_wrap;
`endif

  assign pix_x = 8'(X0 + (int'(idx) % COLS) * SQ_SIZE + int'(px));
  assign pix_y = 7'(Y0 + (int'(idx) / COLS) * SQ_SIZE + int'(py));

  // Grid lines on the top and left edge of every square, fill elsewhere
  always_comb begin
    pix_colour = COL_GRID;
    if (px != '0 && py != '0) begin
      pix_colour = square_colour(snap_blue[idx], snap_red[idx]);
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pass sequencing: wait for a reason to draw, snapshot, scan, report
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending || draw_req || board_changed) state_next = LOAD;
      LOAD:    state_next = DRAW;
      DRAW:    if (draw_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Freeze the board for the pass and remember any change or request that
  // arrives while a pass is already under way.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_blue <= '0;
      snap_red  <= '0;
      pending   <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          snap_blue <= blue;
          snap_red  <= red;
          pending   <= draw_req;
        end
        DRAW, DONE: begin
          if (draw_req || board_changed) pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered adapter outputs; pixel position and colour only move while
  // drawing so they hold their last value otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= (state == DRAW) && !skip;
      busy <= (state == LOAD) || (state == DRAW);
      done <= (state == DONE);
      if (state == DRAW) begin
        x      <= pix_x;
        y      <= pix_y;
        colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: each pass expectation is queued when
// its stimulus is driven and retired when the renderer pulses done.
module tb_board_renderer;
  import plotfour_pkg::*;

  localparam int COLS = 4;
  localparam int NSQ  = 20;
  localparam int SQ   = 16;
  localparam int X0   = 48;
  localparam int Y0   = 20;
  localparam int PIX  = 5120;

  typedef struct {
    int           plots;
    logic [19:0]  b;
    logic [19:0]  r;
    bit           timed;
    int           start;
    bit           ordered;
    int           xmin, xmax, ymin, ymax;
  } pass_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] blue = '0;
  logic [19:0] red = '0;
  logic        draw_req = 1'b0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  pass_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    done_count = 0;
  int    acc_plots = 0, acc_pix_err = 0, acc_order_err = 0, acc_box_err = 0;
  int    first_cyc = 0, last_cyc = 0, busy_cyc = 0;
  logic  busy_prev = 1'b0;
  logic [2:0] fb [160][120];

  board_renderer dut (
    .clock    (clock),
    .reset    (reset),
    .blue     (blue),
    .red      (red),
    .draw_req (draw_req),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  // Reference colour of a frame-buffer pixel for a given board, -1 if off-board
  function automatic int model_colour(int px_, int py_, logic [19:0] b, logic [19:0] r);
    int col, row, sq, ox, oy;
    if (px_ < X0 || px_ >= X0 + COLS * SQ || py_ < Y0 || py_ >= Y0 + 5 * SQ) return -1;
    col = (px_ - X0) / SQ;
    row = (py_ - Y0) / SQ;
    sq  = row * COLS + col;
    ox  = (px_ - X0) % SQ;
    oy  = (py_ - Y0) % SQ;
    if (ox == 0 || oy == 0) return 7;
    case ({b[sq], r[sq]})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b01:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic pass_t full_pass(logic [19:0] b, logic [19:0] r, bit timed);
    pass_t p;
    p.plots = PIX; p.b = b; p.r = r; p.timed = timed; p.start = -1; p.ordered = 1'b1;
    p.xmin = X0; p.xmax = X0 + COLS * SQ - 1; p.ymin = Y0; p.ymax = Y0 + 5 * SQ - 1;
    return p;
  endfunction

  function automatic void clear_acc();
    acc_plots = 0; acc_pix_err = 0; acc_order_err = 0; acc_box_err = 0;
    first_cyc = 0; last_cyc = 0; busy_cyc = 0;
  endfunction

  // Collect plotted pixels, compare against the head expectation, retire on done
  always @(negedge clock) begin
    pass_t cur;
    int k, sq, ex, ey;
    if (reset) begin
      clear_acc();
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) busy_cyc = cyc;
      busy_prev = busy;
      if (plot) begin
        if (acc_plots == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (x < 160 && y < 120) fb[x][y] = colour;
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          if (model_colour(int'(x), int'(y), cur.b, cur.r) != int'(colour)) acc_pix_err++;
          if (int'(x) < cur.xmin || int'(x) > cur.xmax || int'(y) < cur.ymin || int'(y) > cur.ymax)
            acc_box_err++;
          if (cur.ordered) begin
            k  = acc_plots;
            sq = k / (SQ * SQ);
            ex = X0 + (sq % COLS) * SQ + k % SQ;
            ey = Y0 + (sq / COLS) * SQ + (k / SQ) % SQ;
            if (int'(x) != ex || int'(y) != ey) acc_order_err++;
          end
        end else begin
          acc_pix_err++;
        end
        acc_plots++;
      end
      if (done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_pass", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check_output("plot_count", acc_plots, cur.plots);
          check_output("pixel_colour_errors", acc_pix_err, 0);
          check_output("pixel_order_errors", acc_order_err, 0);
          check_output("pixel_outside_box", acc_box_err, 0);
          if (cur.timed) begin
            check_output("busy_rise_cycle", busy_cyc - cur.start, 1);
            check_output("first_plot_cycle", first_cyc - cur.start, 2);
            check_output("last_plot_cycle", last_cyc - cur.start, 5121);
            check_output("done_cycle", cyc - cur.start, 5122);
          end
        end
        clear_acc();
      end
    end
  end

  // Drive a board/request change on a falling edge and queue its pass
  task automatic apply_stimulus(input logic [19:0] b, input logic [19:0] r,
                                input logic req, input pass_t rec);
    @(negedge clock);
    if (rec.timed) rec.start = cyc + 1;
    exp_q.push_back(rec);
    blue = b;
    red = r;
    draw_req = req;
    @(negedge clock);
    draw_req = 1'b0;
  endtask

  task automatic wait_pass(input int budget);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      if (done_count != d0) break;
    end
    check_output("pass_completed", int'(done_count != d0), 1);
  endtask

  task automatic wait_into_pass(input int start, input int n);
    for (int i = 0; i < 10000 && cyc < start + n; i++) @(negedge clock);
  endtask

  initial begin
    pass_t rec;
    int s, d0;

    // Reset state
    repeat (3) @(negedge clock);
    check_output("reset_x", int'(x), 0);
    check_output("reset_y", int'(y), 0);
    check_output("reset_colour", int'(colour), 0);
    check_output("reset_plot", int'(plot), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);

    // First frame is drawn straight out of reset
    @(negedge clock);
    rec = full_pass('0, '0, 1'b1);
    rec.start = cyc + 1;
    exp_q.push_back(rec);
    reset = 1'b0;
    wait_pass(6000);
    check_output("fb_49_21_empty", int'(fb[49][21]), 0);
    check_output("fb_48_21_grid", int'(fb[48][21]), 7);

`ifdef BOARD_RENDERER_DIRTY_ONLY_EN
    // Only the changed square is repainted
    rec = full_pass(20'h00008, '0, 1'b0);
    rec.plots = 256; rec.ordered = 1'b0;
    rec.xmin = 96; rec.xmax = 111; rec.ymin = 20; rec.ymax = 35;
    apply_stimulus(20'h00008, '0, 1'b0, rec);
    wait_pass(6000);
    check_output("fb_sq3_blue", int'(fb[100][25]), 1);
`else
    // A board change in IDLE starts a pass by itself
    apply_stimulus(20'h00020, '0, 1'b0, full_pass(20'h00020, '0, 1'b1));
    wait_pass(6000);
    check_output("fb_sq5_first_interior", int'(fb[65][37]), 1);
    check_output("fb_sq5_last_interior", int'(fb[79][51]), 1);
    check_output("fb_sq5_grid", int'(fb[64][37]), 7);
    check_output("fb_sq0_empty", int'(fb[50][22]), 0);

    // Both players on one square shows the illegal colour
    apply_stimulus(20'h80020, 20'h80000, 1'b0, full_pass(20'h80020, 20'h80000, 1'b1));
    wait_pass(6000);
    check_output("fb_sq19_illegal_a", int'(fb[97][85]), 5);
    check_output("fb_sq19_illegal_b", int'(fb[111][99]), 5);

    // Mid-pass change does not tear, and causes exactly one extra pass
    apply_stimulus(20'h80020, 20'h80000, 1'b1, full_pass(20'h80020, 20'h80000, 1'b1));
    s = exp_q[0].start;
    wait_into_pass(s, 1000);
    exp_q.push_back(full_pass(20'h80020, 20'h80001, 1'b0));
    red = 20'h80001;
    wait_pass(6000);
    check_output("fb_sq0_frozen", int'(fb[50][22]), 0);
    wait_pass(6000);
    check_output("fb_sq0_red", int'(fb[50][22]), 4);
    d0 = done_count;
    repeat (300) @(negedge clock);
    check_output("no_extra_pass", done_count - d0, 0);
    check_output("idle_busy", int'(busy), 0);

    // Reset in the middle of a pass
    apply_stimulus(20'h80020, 20'h80001, 1'b1, full_pass(20'h80020, 20'h80001, 1'b1));
    s = exp_q[0].start;
    wait_into_pass(s, 2500);
    check_output("plot_before_reset", int'(plot), 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_output("plot_in_reset", int'(plot), 0);
    check_output("busy_in_reset", int'(busy), 0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    rec = full_pass(20'h80020, 20'h80001, 1'b1);
    rec.start = cyc + 1;
    exp_q.push_back(rec);
    reset = 1'b0;
    wait_pass(6000);
`endif

    check_output("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
